// File: rtl/mem_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_bridge
// Description : Turns single-cycle MEM-stage load/store requests into a req/ack
//               handshake toward a multi-cycle data memory and stalls the
//               pipeline until each access completes. The optional access
//               timeout is built only when MEM_BUS_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_stall,
    output logic                  mem_err,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q,     state_d;
    logic                    bus_req_q,   bus_req_d;
    logic                    bus_we_q,    bus_we_d;
    logic [ADDR_WIDTH-1:0]   bus_addr_q,  bus_addr_d;
    logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DATA_WIDTH-1:0]   mem_din_q,   mem_din_d;
    logic                    w_access;

    assign w_access = mem_ren | mem_wen;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int            C_CNT_WIDTH = 16;
    localparam logic [DATA_WIDTH-1:0] C_ERR_DATA = DATA_WIDTH'(32'hDEAD_BEEF);
    logic [C_CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                     mem_err_q, mem_err_d;
    logic [C_CNT_WIDTH-1:0]   w_cnt_inc;
    logic                     w_timeout;

    // The count reaches TIMEOUT_CYCLES during the TIMEOUT_CYCLES-th BUSY cycle.
    assign w_cnt_inc = cnt_q + 1'b1;
    assign w_timeout = (w_cnt_inc == C_CNT_WIDTH'(TIMEOUT_CYCLES));
    assign mem_err   = mem_err_q;
`else
    logic [15:0] w_timeout_unused;
    assign w_timeout_unused = 16'(TIMEOUT_CYCLES);
    assign mem_err          = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        mem_din_d   = mem_din_q;
`ifdef MEM_BUS_TIMEOUT_EN
        cnt_d       = cnt_q;
        mem_err_d   = mem_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_access) begin
                    bus_addr_d  = mem_addr;
                    bus_we_d    = mem_wen;
                    bus_wdata_d = mem_dout;
                    bus_req_d   = 1'b1;
                    state_d     = ST_BUSY;
`ifdef MEM_BUS_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            ST_BUSY: begin
                // An ack coinciding with the timeout takes priority.
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        mem_din_d = bus_rdata;
                    end
                    state_d = ST_DONE;
                end
`ifdef MEM_BUS_TIMEOUT_EN
                else if (w_timeout) begin
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        mem_din_d = C_ERR_DATA;
                    end
                    mem_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = w_cnt_inc;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            mem_din_q   <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q       <= '0;
            mem_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            mem_din_q   <= mem_din_d;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
            mem_err_q   <= mem_err_d;
`endif
        end
    end

    // DONE drops the stall so the pipeline advances on the following edge.
    assign mem_stall = ((state_q == ST_IDLE) && w_access) || (state_q == ST_BUSY);
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign mem_din   = mem_din_q;

endmodule
`default_nettype wire
